// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter state type, counter width and sizing helper
package arb_pkg;
  typedef enum logic {IDLE, GRANT} state_e;
  localparam int HOLD_W = 8;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r < 1 ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: masked rotating priority encoder, first candidate at or after start wins
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic [N-1:0]  excl_i,
  output logic [N-1:0]  win_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);
  logic [N-1:0] cand;
  int j;
  assign cand = req_i & ~excl_i;
  // scan upward from start, wrapping past N-1 back to 0
  always_comb begin
    win_o = '0;
    idx_o = '0;
    found_o = 1'b0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start_i) + k;
      j = j >= N ? j - N : j;
      if (!found_o && cand[j]) begin
        win_o[j] = 1'b1;
        idx_o = IW'(j);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-requester round-robin/fixed-priority arbiter with registered one-hot grant and hold limit
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MODE_RR = 1,
  parameter int MAX_HOLD = 8,
  localparam int IDX_W = clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_id,
  output logic [HOLD_W-1:0] hold_cnt
);
  state_e state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, win;
  logic vld_q, vld_d, held, others, hand_off, keep, found;
  logic [IDX_W-1:0] id_q, id_d, ptr_q, ptr_d, win_idx;
  logic [HOLD_W-1:0] hold_q, hold_d;
  assign held = |(req & gnt_q);
  assign others = |(req & ~gnt_q);
  assign hand_off = held && others && MAX_HOLD != 0 && int'(hold_q) >= MAX_HOLD;
  assign keep = state_q == GRANT && held && !hand_off;
  rr_pick #(.N(NREQ), .IW(IDX_W)) u_pick (
    .req_i(req),
    .start_i(MODE_RR != 0 ? ptr_q : '0),
    .excl_i(hand_off ? gnt_q : '0),
    .win_o(win),
    .idx_o(win_idx),
    .found_o(found)
  );
  // keep the holder, hand to the next winner with no bubble, or fall back to idle
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    vld_d = vld_q;
    id_d = id_q;
    hold_d = hold_q;
    ptr_d = ptr_q;
    if (keep) hold_d = hold_q == '1 ? hold_q : hold_q + 1'b1;
    else if (found) begin
      state_d = GRANT;
      gnt_d = win;
      vld_d = 1'b1;
      id_d = win_idx;
      hold_d = HOLD_W'(1);
      ptr_d = MODE_RR == 0 ? '0 : win_idx == IDX_W'(NREQ - 1) ? '0 : win_idx + 1'b1;
    end else begin
      state_d = IDLE;
      gnt_d = '0;
      vld_d = 1'b0;
      id_d = '0;
      hold_d = '0;
    end
  end
  // grant state register, reset wins over any grant in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      vld_q <= 1'b0;
      id_q <= '0;
      hold_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      vld_q <= vld_d;
      id_q <= id_d;
      hold_q <= hold_d;
      ptr_q <= ptr_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_valid = vld_q;
  assign gnt_id = id_q;
  assign hold_cnt = hold_q;
endmodule
